// File: rtl/rom_ctrl_access_arb.sv
// rom_ctrl_access_arb: owns the single ROM read port.
//   After reset the checker (address counter feeding KMAC) drives the ROM. Once the checker
//   reports done, one drain cycle lets its last read complete, then the port belongs to the
//   bus side until the next reset. A sticky alert is raised if done ever falls or if the
//   check phase overruns CheckTimeout cycles.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   chk_req_i/chk_addr_i          checker read request/address
//   chk_done_i                    checker finished (must stay high once set)
//   bus_req_i/bus_addr_i          bus read request/address, held until granted
//   bus_gnt_o                     bus request accepted this cycle
//   bus_rvalid_o/bus_err_o        bus response valid, qualified by out-of-range error
//   rom_req_o/rom_addr_o          ROM read enable/address
//   sel_bus_o                     ROM data belongs to the bus side
//   alert_o                       sticky fatal alert
module rom_ctrl_access_arb #(
   parameter  int unsigned RomDepth     = 16,
   parameter  int unsigned CheckTimeout = 64,
   localparam int unsigned AW           = (RomDepth > 1) ? $clog2(RomDepth) : 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          chk_req_i,
   input  logic [AW-1:0] chk_addr_i,
   input  logic          chk_done_i,
   input  logic          bus_req_i,
   input  logic [AW-1:0] bus_addr_i,
   output logic          bus_gnt_o,
   output logic          bus_rvalid_o,
   output logic          bus_err_o,
   output logic          rom_req_o,
   output logic [AW-1:0] rom_addr_o,
   output logic          sel_bus_o,
   output logic          alert_o
);

   // Timeout counter only needs to reach CheckTimeout-1, where it saturates.
   localparam int unsigned TW          = (CheckTimeout > 2) ? $clog2(CheckTimeout) : 1;
   localparam int unsigned TMax        = (CheckTimeout > 0) ? CheckTimeout - 1 : 0;
   localparam bit          DepthIsPow2 = (RomDepth == (32'd1 << AW));

   typedef enum logic [1:0] {
      ST_CHECK = 2'd0,
      ST_DRAIN = 2'd1,
      ST_BUS   = 2'd2,
      ST_ERROR = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   tmo_cnt_q;
   logic            tmo_hit_c;
   logic            oor_c;
   logic            gnt_c;
   logic            req_c;
   logic [AW-1:0]   addr_c;
   logic            sel_c;
   logic            rvalid_q;
   logic            err_q;
   logic            alert_q;

   // Out-of-range bus address; all encodings are legal for a power-of-2 depth.
   assign oor_c     = !DepthIsPow2 && ({1'b0, bus_addr_i} >= (AW + 1)'(RomDepth));
   assign tmo_hit_c = (CheckTimeout != 0) && (tmo_cnt_q == TW'(TMax));

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_CHECK;
      end else begin
         state_q <= state_d;
      end
   end

   // Check-phase cycle counter, saturating.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tmo_cnt_q <= '0;
      end else if (state_q == ST_CHECK && tmo_cnt_q != TW'(TMax)) begin
         tmo_cnt_q <= tmo_cnt_q + TW'(1);
      end
   end

   // Next state and combinational port steering; done wins over a simultaneous timeout.
   always_comb begin
      state_d = state_q;
      gnt_c   = 1'b0;
      req_c   = 1'b0;
      addr_c  = '0;
      sel_c   = 1'b0;
      case (state_q)
         ST_CHECK: begin
            req_c  = chk_req_i;
            addr_c = chk_req_i ? chk_addr_i : '0;
            if (chk_done_i) begin
               state_d = ST_DRAIN;
            end else if (tmo_hit_c) begin
               state_d = ST_ERROR;
            end
         end
         ST_DRAIN: begin
            state_d = chk_done_i ? ST_BUS : ST_ERROR;
         end
         ST_BUS: begin
            sel_c = 1'b1;
            if (!chk_done_i) begin
               state_d = ST_ERROR;
            end else begin
               gnt_c  = bus_req_i;
               req_c  = bus_req_i && !oor_c;
               addr_c = (bus_req_i && !oor_c) ? bus_addr_i : '0;
            end
         end
         ST_ERROR: begin
            state_d = ST_ERROR;
         end
         default: begin
            state_d = ST_ERROR;
         end
      endcase
      // Outputs are held quiet while reset is asserted.
      if (rst_i) begin
         gnt_c  = 1'b0;
         req_c  = 1'b0;
         addr_c = '0;
         sel_c  = 1'b0;
      end
   end

   // Bus response, one cycle after the grant; alert latches on entry to ERROR.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         alert_q  <= 1'b0;
      end else begin
         rvalid_q <= gnt_c;
         err_q    <= gnt_c && oor_c;
         alert_q  <= alert_q || (state_d == ST_ERROR);
      end
   end

   assign bus_gnt_o    = gnt_c;
   assign rom_req_o    = req_c;
   assign rom_addr_o   = addr_c;
   assign sel_bus_o    = sel_c;
   assign bus_rvalid_o = rvalid_q && !rst_i;
   assign bus_err_o    = err_q && !rst_i;
   assign alert_o      = alert_q && !rst_i;

endmodule

// File: tb/tb_rom_ctrl_access_arb.sv
// tb_rom_ctrl_access_arb: drives three arbiter instances (16/64, 12/8, 16/no-timeout) from
// shared inputs and compares every output each cycle against a cycle-index reference model,
// plus explicit checks for each scenario.
module tb_rom_ctrl_access_arb;
   localparam int AW = 4;
   localparam int NI = 3;
   localparam int B_GNT = 9, B_RV = 8, B_ERR = 7, B_REQ = 6, B_SEL = 1, B_AL = 0;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          chk_req_i = 1'b0;
   logic [AW-1:0] chk_addr_i = '0;
   logic          chk_done_i = 1'b0;
   logic          bus_req_i = 1'b0;
   logic [AW-1:0] bus_addr_i = '0;

   logic          gnt [NI], rv [NI], er [NI], rq [NI], sl [NI], al [NI];
   logic [AW-1:0] ad [NI];
   logic [9:0]    obs [NI];
   logic [9:0]    obs_s [NI];

   int n_checks = 0;
   int n_err = 0;

   // model: cycles since reset, handover cycle, first ERROR cycle, previous grant / oor grant
   int mk [NI], mh [NI], merr [NI];
   bit mpg [NI], mpe [NI];

   always #5 clk_i = ~clk_i;

   rom_ctrl_access_arb #(.RomDepth(16), .CheckTimeout(64)) u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .chk_req_i(chk_req_i), .chk_addr_i(chk_addr_i),
      .chk_done_i(chk_done_i), .bus_req_i(bus_req_i), .bus_addr_i(bus_addr_i),
      .bus_gnt_o(gnt[0]), .bus_rvalid_o(rv[0]), .bus_err_o(er[0]), .rom_req_o(rq[0]),
      .rom_addr_o(ad[0]), .sel_bus_o(sl[0]), .alert_o(al[0]));

   rom_ctrl_access_arb #(.RomDepth(12), .CheckTimeout(8)) u_d12 (
      .clk_i(clk_i), .rst_i(rst_i), .chk_req_i(chk_req_i), .chk_addr_i(chk_addr_i),
      .chk_done_i(chk_done_i), .bus_req_i(bus_req_i), .bus_addr_i(bus_addr_i),
      .bus_gnt_o(gnt[1]), .bus_rvalid_o(rv[1]), .bus_err_o(er[1]), .rom_req_o(rq[1]),
      .rom_addr_o(ad[1]), .sel_bus_o(sl[1]), .alert_o(al[1]));

   rom_ctrl_access_arb #(.RomDepth(16), .CheckTimeout(0)) u_t0 (
      .clk_i(clk_i), .rst_i(rst_i), .chk_req_i(chk_req_i), .chk_addr_i(chk_addr_i),
      .chk_done_i(chk_done_i), .bus_req_i(bus_req_i), .bus_addr_i(bus_addr_i),
      .bus_gnt_o(gnt[2]), .bus_rvalid_o(rv[2]), .bus_err_o(er[2]), .rom_req_o(rq[2]),
      .rom_addr_o(ad[2]), .sel_bus_o(sl[2]), .alert_o(al[2]));

   for (genvar g = 0; g < NI; g++) begin : g_obs
      assign obs[g] = {gnt[g], rv[g], er[g], rq[g], ad[g], sl[g], al[g]};
   end

   function automatic int depth_of(input int i);
      return (i == 1) ? 12 : 16;
   endfunction

   function automatic int tmo_of(input int i);
      return (i == 0) ? 64 : ((i == 1) ? 8 : 0);
   endfunction

   task automatic set_in(input bit cr, input logic [AW-1:0] ca, input bit dn,
                         input bit br, input logic [AW-1:0] ba);
      chk_req_i = cr; chk_addr_i = ca; chk_done_i = dn; bus_req_i = br; bus_addr_i = ba;
   endtask

   // One clock cycle: compare all instances against the model, then advance.
   task automatic step(input string tag);
      @(negedge clk_i);
      for (int i = 0; i < NI; i++) begin
         bit g, q, s, a, v, e, oor;
         logic [AW-1:0] ea;
         logic [9:0] ex;
         int ba;
         g = 0; q = 0; s = 0; a = 0; v = 0; e = 0; oor = 0; ea = '0;
         ba = {28'd0, bus_addr_i};
         oor = (ba >= depth_of(i));
         if (!rst_i) begin
            v = mpg[i]; e = mpe[i];
            if (merr[i] >= 0 && mk[i] >= merr[i]) begin
               a = 1;
            end else if (mh[i] < 0) begin
               q = chk_req_i; ea = chk_req_i ? chk_addr_i : '0;
            end else if (mk[i] == mh[i] + 1) begin
               q = 0;
            end else begin
               s = 1;
               if (chk_done_i) begin
                  g = bus_req_i; q = bus_req_i && !oor; ea = q ? bus_addr_i : '0;
               end
            end
         end
         ex = {g, v, e, q, ea, s, a};
         obs_s[i] = obs[i];
         n_checks++;
         if (obs[i] !== ex) begin
            n_err++;
            $display("FAIL %s inst%0d k=%0d got %b exp %b", tag, i, mk[i], obs[i], ex);
         end
         if (rst_i) begin
            mk[i] = 0; mh[i] = -1; merr[i] = -1; mpg[i] = 0; mpe[i] = 0;
         end else begin
            if (!(merr[i] >= 0 && mk[i] >= merr[i])) begin
               if (mh[i] < 0) begin
                  if (chk_done_i) mh[i] = mk[i];
                  else if (tmo_of(i) != 0 && mk[i] >= tmo_of(i) - 1) merr[i] = mk[i] + 1;
               end else if (!chk_done_i) begin
                  merr[i] = mk[i] + 1;
               end
            end
            mpg[i] = g; mpe[i] = g && oor;
            mk[i]++;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      set_in(0, '0, 0, 0, '0);
      step("rst");
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      set_in(1, 4'd5, 1, 1, 4'd7);
      step("reset");
      step("reset");
      for (int i = 0; i < NI; i++) begin
         n_checks++;
         if (obs_s[i] !== 10'd0) begin
            n_err++; $display("FAIL reset_during inst%0d got %b exp %b", i, obs_s[i], 10'd0);
         end
      end
      rst_i = 1'b0;
      set_in(0, '0, 0, 1, 4'd7);
      step("reset_after");
      for (int i = 0; i < NI; i++) begin
         n_checks++;
         if (obs_s[i] !== 10'd0) begin
            n_err++; $display("FAIL reset_after inst%0d got %b exp %b", i, obs_s[i], 10'd0);
         end
      end
   endtask

   task automatic test_handover();
      int first_g, first_v, alerts, drain_req;
      first_g = -1; first_v = -1; alerts = 0; drain_req = 1;
      do_reset();
      for (int c = 0; c < 30; c++) begin
         set_in(1, 4'(c), c >= 20, c >= 5, 4'd3);
         step("handover");
         if (obs_s[0][B_GNT] && first_g < 0) first_g = c;
         if (obs_s[0][B_RV] && first_v < 0) first_v = c;
         if (obs_s[0][B_AL]) alerts++;
         if (c == 21) drain_req = obs_s[0][B_REQ];
      end
      n_checks++;
      if (first_g != 22) begin n_err++; $display("FAIL handover_gnt got %0d exp 22", first_g); end
      n_checks++;
      if (first_v != 23) begin n_err++; $display("FAIL handover_rvalid got %0d exp 23", first_v); end
      n_checks++;
      if (drain_req != 0) begin n_err++; $display("FAIL drain_req got %0d exp 0", drain_req); end
      n_checks++;
      if (alerts != 0) begin n_err++; $display("FAIL handover_alert got %0d exp 0", alerts); end
   endtask

   task automatic test_oor();
      do_reset();
      set_in(0, '0, 1, 0, '0); step("oor");
      step("oor");
      set_in(0, '0, 1, 1, 4'd13); step("oor");
      n_checks++;
      if (obs_s[1][B_GNT] !== 1'b1 || obs_s[1][B_REQ] !== 1'b0) begin
         n_err++; $display("FAIL oor_gnt gnt=%b req=%b exp gnt=1 req=0", obs_s[1][B_GNT], obs_s[1][B_REQ]);
      end
      n_checks++;
      if (obs_s[0][B_REQ] !== 1'b1 || obs_s[0][5:2] !== 4'd13) begin
         n_err++; $display("FAIL inrange16 got %b exp req=1 addr=13", obs_s[0]);
      end
      set_in(0, '0, 1, 1, 4'd11); step("oor");
      n_checks++;
      if (obs_s[1][B_RV] !== 1'b1 || obs_s[1][B_ERR] !== 1'b1) begin
         n_err++; $display("FAIL oor_resp rv=%b err=%b exp 1 1", obs_s[1][B_RV], obs_s[1][B_ERR]);
      end
      n_checks++;
      if (obs_s[1][B_REQ] !== 1'b1 || obs_s[0][B_ERR] !== 1'b0) begin
         n_err++; $display("FAIL addr11 got %b / %b exp req=1 err16=0", obs_s[1], obs_s[0]);
      end
      set_in(0, '0, 1, 0, '0); step("oor");
      n_checks++;
      if (obs_s[1][B_RV] !== 1'b1 || obs_s[1][B_ERR] !== 1'b0) begin
         n_err++; $display("FAIL ok_resp rv=%b err=%b exp 1 0", obs_s[1][B_RV], obs_s[1][B_ERR]);
      end
   endtask

   task automatic test_done_drop();
      int low;
      low = 0;
      do_reset();
      for (int c = 0; c < 5; c++) begin
         set_in(0, '0, 1, 1, 4'(c)); step("drop");
      end
      set_in(0, '0, 0, 1, 4'd5); step("drop");
      n_checks++;
      if (obs_s[0][B_GNT] !== 1'b0 || obs_s[0][B_REQ] !== 1'b0 || obs_s[0][B_RV] !== 1'b1) begin
         n_err++; $display("FAIL drop_gnt got %b exp gnt=0 req=0 rv=1", obs_s[0]);
      end
      for (int c = 0; c < 100; c++) begin
         set_in(1'($urandom), 4'($urandom), 1'($urandom), 1, 4'($urandom));
         step("drop");
         if (obs_s[0][B_AL] !== 1'b1 || obs_s[0][B_GNT] !== 1'b0) low++;
      end
      n_checks++;
      if (low != 0) begin n_err++; $display("FAIL sticky_alert bad_cycles got %0d exp 0", low); end
      do_reset();
      step("drop");
      n_checks++;
      if (obs_s[0][B_AL] !== 1'b0) begin n_err++; $display("FAIL alert_cleared got 1 exp 0"); end
   endtask

   task automatic test_timeout();
      int first [NI];
      do_reset();
      for (int i = 0; i < NI; i++) first[i] = -1;
      for (int c = 0; c < 1000; c++) begin
         set_in(1'($urandom), 4'($urandom), 0, 1'($urandom), 4'($urandom));
         step("timeout");
         for (int i = 0; i < NI; i++) if (obs_s[i][B_AL] && first[i] < 0) first[i] = c;
      end
      n_checks++;
      if (first[1] != 8) begin n_err++; $display("FAIL timeout8 got %0d exp 8", first[1]); end
      n_checks++;
      if (first[0] != 64) begin n_err++; $display("FAIL timeout64 got %0d exp 64", first[0]); end
      n_checks++;
      if (first[2] != -1) begin n_err++; $display("FAIL timeout0 got %0d exp -1", first[2]); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int c = 0; c < 4; c++) begin
         set_in(0, '0, 1, 1, 4'd9); step("rstmid");
      end
      n_checks++;
      if (obs_s[0][B_GNT] !== 1'b1) begin n_err++; $display("FAIL rstmid_gnt got 0 exp 1"); end
      rst_i = 1'b1;
      step("rstmid");
      rst_i = 1'b0;
      set_in(0, '0, 1, 1, 4'd9);
      step("rstmid");
      n_checks++;
      if (obs_s[0] !== 10'd0) begin n_err++; $display("FAIL rstmid_out got %b exp %b", obs_s[0], 10'd0); end
   endtask

   task automatic test_back_to_back();
      int grants, rvalids, bad_addr;
      grants = 0; rvalids = 0; bad_addr = 0;
      do_reset();
      set_in(0, '0, 1, 0, '0); step("b2b");
      step("b2b");
      for (int c = 0; c < 17; c++) begin
         if (c < 16) set_in(0, '0, 1, 1, 4'(c));
         else set_in(0, '0, 1, 0, '0);
         step("b2b");
         if (c < 16 && obs_s[0][B_GNT]) grants++;
         if (c < 16 && (obs_s[0][B_REQ] !== 1'b1 || obs_s[0][5:2] !== 4'(c))) bad_addr++;
         if (c > 0 && obs_s[0][B_RV] && !obs_s[0][B_ERR]) rvalids++;
      end
      n_checks++;
      if (grants != 16) begin n_err++; $display("FAIL b2b_grants got %0d exp 16", grants); end
      n_checks++;
      if (rvalids != 16) begin n_err++; $display("FAIL b2b_rvalids got %0d exp 16", rvalids); end
      n_checks++;
      if (bad_addr != 0) begin n_err++; $display("FAIL b2b_addr got %0d bad exp 0", bad_addr); end
   endtask

   task automatic test_random();
      for (int ep = 0; ep < 20; ep++) begin
         int done_at, drop_at;
         do_reset();
         done_at = int'($urandom_range(0, 90));
         drop_at = ($urandom_range(0, 3) == 0) ? done_at + int'($urandom_range(1, 30)) : -1;
         for (int c = 0; c < 120; c++) begin
            set_in(1'($urandom), 4'($urandom),
                   (c >= done_at) && !(drop_at >= 0 && c >= drop_at),
                   $urandom_range(0, 3) != 0, 4'($urandom));
            step("random");
         end
      end
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         mk[i] = 0; mh[i] = -1; merr[i] = -1; mpg[i] = 0; mpe[i] = 0;
      end
      @(posedge clk_i);
      #1;
      test_reset();
      test_handover();
      test_oor();
      test_done_drop();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
